// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential divider.
// Imported by the step cell and the divider top.
package div_pkg;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;
  localparam int CNT_W  = $clog2(DW_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module div_step
  import div_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW:0]   p_in,
  input  logic          d_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   p_out,
  output logic          q_bit
);

  logic [VW:0] p_sh;
  logic        unused_msb;

  // p_in is always below the divisor, so its msb is zero
  assign unused_msb = p_in[VW];

  // Trial subtraction decides the quotient bit
  always_comb begin
    p_sh  = {p_in[VW-1:0], d_bit};
    q_bit = (p_sh >= {1'b0, divisor});
    p_out = q_bit ? (p_sh - {1'b0, divisor}) : p_sh;
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit
// per clock, with start/busy/done handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quot,
  output logic [VW-1:0] rem,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t        state;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dvs;
  logic [VW:0]   p;
  logic [CW-1:0] cnt;

  logic [VW:0]   p_nxt;
  logic          q_bit;

  div_step #(
    .VW(VW)
  ) u_step (
    .p_in   (p),
    .d_bit  (dvd[DW-1]),
    .divisor(dvs),
    .p_out  (p_nxt),
    .q_bit  (q_bit)
  );

  // FSM, operand shift register and registered results;
  // quotient bits fill the dividend register from the lsb
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      p           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            dvd <= dividend;
            dvs <= divisor;
            p   <= '0;
            cnt <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              quot        <= '1;
              rem         <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              busy        <= 1'b1;
              quot        <= '0;
              rem         <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          dvd <= {dvd[DW-2:0], q_bit};
          p   <= p_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            quot  <= {dvd[DW-2:0], q_bit};
            rem   <= p_nxt[VW-1:0];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
